// File: rtl/iod_dly_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iod_dly_ctrl_pkg
// Shared types for the IOD dynamic delay-line step sequencer:
//   op_e     - request opcode (load / increment / decrement / illegal)
//   status_e - completion status reported with DONE_VALID
//   state_e  - sequencer FSM states
// ----------------------------------------------------------------------------
package iod_dly_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD    = 2'b00,
        OP_INC     = 2'b01,
        OP_DEC     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_OOR     = 2'b01,
        ST_ILLEGAL = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MOVE,
        S_SETTLE,
        S_LOAD,
        S_DONE
    } state_e;

    // Width of the optional out-of-range completion counter.
    localparam int OOR_CNT_W = 8;

endpackage

// File: rtl/iod_dly_tap_cnt.sv
// ----------------------------------------------------------------------------
// iod_dly_tap_cnt
// Tracked tap value of one IOD delay line. Load restores LOAD_TAP; inc/dec
// move by one tap. Range limits are enforced by the sequencer, not here.
// Ports:
//   clk, srst      - clock, synchronous active-high reset (tap -> LOAD_TAP)
//   load_i         - restore LOAD_TAP (highest priority)
//   inc_i, dec_i   - step up / down by one
//   tap_o          - current tap
// ----------------------------------------------------------------------------
module iod_dly_tap_cnt #(
    parameter int TAP_W    = 8,
    parameter int LOAD_TAP = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [TAP_W-1:0] tap_o
);

    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] tap_d;

    always_comb begin
        tap_d = tap_q;
        if (load_i) begin
            tap_d = TAP_W'(LOAD_TAP);
        end else if (inc_i) begin
            tap_d = tap_q + 1'b1;
        end else if (dec_i) begin
            tap_d = tap_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tap_q <= TAP_W'(LOAD_TAP);
        end else begin
            tap_q <= tap_d;
        end
    end

    assign tap_o = tap_q;

endmodule

// File: rtl/iod_dly_step_ctrl.sv
// ----------------------------------------------------------------------------
// iod_dly_step_ctrl
// Converts load / increment / decrement requests into spaced LOAD, MOVE and
// DIRECTION pulses for one addressed IOD delay lane, tracking tap per lane.
// Optional feature macro: IOD_DLY_OOR_CNT_EN adds OOR_COUNT (saturating count
// of out-of-range completions).
// Ports:
//   FAB_CLK, SYNC_RST         - clock, synchronous active-high reset
//   REQ_VALID/READY/LANE/OP/STEPS - request handshake (accepted in IDLE)
//   DONE_VALID/STATUS/TAPS    - one-cycle completion report
//   BUSY                      - sequencer not idle
//   DELAY_LINE_LOAD/MOVE/DIRECTION - per-lane IOD controls
//   DELAY_LINE_OUT_OF_RANGE   - per-lane IOD range flag
//   TAP_COUNT                 - tracked tap per lane, lane 0 in LSBs
//   OOR_COUNT                 - (IOD_DLY_OOR_CNT_EN only)
// ----------------------------------------------------------------------------
module iod_dly_step_ctrl
    import iod_dly_ctrl_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int TAP_W      = 8,
    parameter int MAX_TAP    = 255,
    parameter int LOAD_TAP   = 1,
    parameter int SETTLE_CYC = 4,
    localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       FAB_CLK,
    input  logic                       SYNC_RST,
    input  logic                       REQ_VALID,
    output logic                       REQ_READY,
    input  logic [LANE_W-1:0]          REQ_LANE,
    input  logic [1:0]                 REQ_OP,
    input  logic [TAP_W-1:0]           REQ_STEPS,
    output logic                       DONE_VALID,
    output logic [1:0]                 DONE_STATUS,
    output logic [TAP_W-1:0]           DONE_TAPS,
    output logic                       BUSY,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
`ifdef IOD_DLY_OOR_CNT_EN
    output logic [OOR_CNT_W-1:0]       OOR_COUNT,
`endif
    output logic [NUM_LANES*TAP_W-1:0] TAP_COUNT
);

    localparam int LANE_SPAN = 1 << LANE_W;
    localparam int CNT_W     = $clog2(SETTLE_CYC + 1);

    state_e                state_q;
    logic [LANE_W-1:0]     lane_q;
    op_e                   op_q;
    logic [TAP_W-1:0]      steps_q;
    logic [TAP_W-1:0]      taps_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_LANES-1:0]  load_q;
    logic [NUM_LANES-1:0]  move_q;
    logic [NUM_LANES-1:0]  dir_q;
    logic                  done_valid_q;
    status_e               status_q;

    logic [LANE_SPAN-1:0]  lane_legal;
    logic [NUM_LANES-1:0]  req_sel;
    logic [NUM_LANES-1:0]  cur_sel;
    logic [NUM_LANES-1:0]  tap_load;
    logic [NUM_LANES-1:0]  tap_inc;
    logic [NUM_LANES-1:0]  tap_dec;
    logic [TAP_W-1:0]      tap_arr [NUM_LANES];
    logic [TAP_W-1:0]      cur_tap;
    logic [TAP_W-1:0]      taps_nxt;
    logic                  oor_cur;
    logic                  settle_last;
    logic                  step_ok;
    logic                  lim_now;
    logic                  lim_next;

    // Lane codes that the port can express but that have no lane behind them
    // are flagged illegal here, so no range compare against NUM_LANES is needed.
    for (genvar gi = 0; gi < LANE_SPAN; gi++) begin : g_legal
        assign lane_legal[gi] = (gi < NUM_LANES) ? 1'b1 : 1'b0;
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign req_sel[gi]  = (REQ_LANE == LANE_W'(gi));
        assign cur_sel[gi]  = (lane_q == LANE_W'(gi));
        assign tap_load[gi] = settle_last && (op_q == OP_LOAD) && cur_sel[gi];
        assign tap_inc[gi]  = step_ok && (op_q == OP_INC) && cur_sel[gi];
        assign tap_dec[gi]  = step_ok && (op_q == OP_DEC) && cur_sel[gi];

        iod_dly_tap_cnt #(
            .TAP_W    (TAP_W),
            .LOAD_TAP (LOAD_TAP)
        ) u_tap_cnt (
            .clk    (FAB_CLK),
            .srst   (SYNC_RST),
            .load_i (tap_load[gi]),
            .inc_i  (tap_inc[gi]),
            .dec_i  (tap_dec[gi]),
            .tap_o  (tap_arr[gi])
        );

        assign TAP_COUNT[gi*TAP_W +: TAP_W] = tap_arr[gi];
    end

    always_comb begin
        cur_tap = '0;
        oor_cur = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (cur_sel[i]) begin
                cur_tap = tap_arr[i];
                oor_cur = DELAY_LINE_OUT_OF_RANGE[i];
            end
        end
    end

    assign settle_last = (state_q == S_SETTLE) && (cnt_q == '0);
    assign step_ok     = settle_last && ((op_q == OP_INC) || (op_q == OP_DEC)) && !oor_cur;
    assign taps_nxt    = taps_q + 1'b1;
    // lim_now: the tap is already at the limit (pre-check before first move).
    // lim_next: the step completing this cycle lands on the limit, so the
    // following step's pre-check would fail; the tap counter only updates on
    // this same edge, hence the look-ahead.
    assign lim_now  = (op_q == OP_INC) ? (cur_tap == TAP_W'(MAX_TAP))
                                       : (cur_tap == '0);
    assign lim_next = (op_q == OP_INC) ? (cur_tap == TAP_W'(MAX_TAP - 1))
                                       : (cur_tap == TAP_W'(1));

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            op_q         <= OP_LOAD;
            steps_q      <= '0;
            taps_q       <= '0;
            cnt_q        <= '0;
            load_q       <= '0;
            move_q       <= '0;
            dir_q        <= '0;
            done_valid_q <= 1'b0;
            status_q     <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        lane_q  <= REQ_LANE;
                        op_q    <= op_e'(REQ_OP);
                        steps_q <= REQ_STEPS;
                        taps_q  <= '0;
                        if (!lane_legal[REQ_LANE] || (op_e'(REQ_OP) == OP_ILLEGAL)) begin
                            state_q      <= S_DONE;
                            done_valid_q <= 1'b1;
                            status_q     <= ST_ILLEGAL;
                        end else if (op_e'(REQ_OP) == OP_LOAD) begin
                            state_q <= S_LOAD;
                            load_q  <= req_sel;
                        end else begin
                            // Direction set here so it is stable a full cycle
                            // (SETUP) before the first MOVE.
                            state_q <= S_SETUP;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (req_sel[i]) begin
                                    dir_q[i] <= (op_e'(REQ_OP) == OP_INC);
                                end
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (steps_q == '0) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        status_q     <= ST_OK;
                    end else if (lim_now) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        status_q     <= ST_OOR;
                    end else begin
                        state_q <= S_MOVE;
                        move_q  <= cur_sel;
                    end
                end
                S_MOVE, S_LOAD: begin
                    move_q  <= '0;
                    load_q  <= '0;
                    state_q <= S_SETTLE;
                    cnt_q   <= CNT_W'(SETTLE_CYC - 1);
                end
                S_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (op_q == OP_LOAD) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        status_q     <= ST_OK;
                    end else if (oor_cur) begin
                        state_q      <= S_DONE;
                        done_valid_q <= 1'b1;
                        status_q     <= ST_OOR;
                    end else begin
                        taps_q <= taps_nxt;
                        if (taps_nxt == steps_q) begin
                            state_q      <= S_DONE;
                            done_valid_q <= 1'b1;
                            status_q     <= ST_OK;
                        end else if (lim_next) begin
                            state_q      <= S_DONE;
                            done_valid_q <= 1'b1;
                            status_q     <= ST_OOR;
                        end else begin
                            state_q <= S_MOVE;
                            move_q  <= cur_sel;
                        end
                    end
                end
                S_DONE: begin
                    done_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IOD_DLY_OOR_CNT_EN
    logic [OOR_CNT_W-1:0] oor_cnt_q;

    // DONE lasts exactly one cycle per completion, so this counts completions.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            oor_cnt_q <= '0;
        end else if ((state_q == S_DONE) && (status_q == ST_OOR) && (oor_cnt_q != '1)) begin
            oor_cnt_q <= oor_cnt_q + 1'b1;
        end
    end

    assign OOR_COUNT = oor_cnt_q;
`endif

    assign REQ_READY            = (state_q == S_IDLE);
    assign BUSY                 = (state_q != S_IDLE);
    assign DONE_VALID           = done_valid_q;
    assign DONE_STATUS          = status_q;
    assign DONE_TAPS            = taps_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_iod_dly_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_iod_dly_step_ctrl
// Directed, table-driven bench for iod_dly_step_ctrl with default parameters
// (NUM_LANES=2, TAP_W=8, MAX_TAP=255, LOAD_TAP=1, SETTLE_CYC=4). Cycle k is
// observed on the falling edge after the k-th rising edge following accept.
// ----------------------------------------------------------------------------
module tb_iod_dly_step_ctrl;

    logic        FAB_CLK = 1'b0;
    logic        SYNC_RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [0:0]  REQ_LANE;
    logic [1:0]  REQ_OP;
    logic [7:0]  REQ_STEPS;
    logic        DONE_VALID;
    logic [1:0]  DONE_STATUS;
    logic [7:0]  DONE_TAPS;
    logic        BUSY;
    logic [1:0]  DELAY_LINE_LOAD;
    logic [1:0]  DELAY_LINE_MOVE;
    logic [1:0]  DELAY_LINE_DIRECTION;
    logic [1:0]  DELAY_LINE_OUT_OF_RANGE;
    logic [15:0] TAP_COUNT;
`ifdef IOD_DLY_OOR_CNT_EN
    logic [7:0]  OOR_COUNT;
`endif

    always #5 FAB_CLK = ~FAB_CLK;

    iod_dly_step_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_LANE                (REQ_LANE),
        .REQ_OP                  (REQ_OP),
        .REQ_STEPS               (REQ_STEPS),
        .DONE_VALID              (DONE_VALID),
        .DONE_STATUS             (DONE_STATUS),
        .DONE_TAPS               (DONE_TAPS),
        .BUSY                    (BUSY),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
`ifdef IOD_DLY_OOR_CNT_EN
        .OOR_COUNT               (OOR_COUNT),
`endif
        .TAP_COUNT               (TAP_COUNT)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One request record: stimulus, OOR-forcing window and expected results.
    typedef struct {
        int lane;
        int op;
        int steps;
        int oor_lo;
        int oor_hi;
        int done_cyc;
        int status;
        int taps;
        int moves;
        int load_cyc;
        int tap0;
        int tap1;
        int dir;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge FAB_CLK);
        while (REQ_READY !== 1'b1 && k < 100) begin
            @(negedge FAB_CLK);
            k++;
        end
        if (k >= 100) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        vec_t v;
        int   n_moves, first_mv, last_mv, load_seen, done_cyc, oor_exp;
        logic rst_done_seen;

        //            lane op stp olo ohi done st tps mv ld t0 t1 dir
        vecs[0] = '{1, 0, 0, 0, -1,  6, 0, 0, 0, 1, 1, 1, 0}; // load lane 1
        vecs[1] = '{0, 1, 3, 0, -1, 17, 0, 3, 3, 0, 4, 1, 1}; // inc 3 from 1
        vecs[2] = '{0, 2, 2, 0, -1, 12, 0, 2, 2, 0, 2, 1, 0}; // dec 2 from 4
        vecs[3] = '{0, 2, 5, 0, -1, 12, 1, 2, 2, 0, 0, 1, 0}; // dec 5 from 2: abort at 0
        vecs[4] = '{0, 2, 1, 0, -1,  2, 1, 0, 0, 0, 0, 1, 0}; // dec at 0: pre-check abort
        vecs[5] = '{1, 1, 4, 8, 11, 12, 1, 1, 2, 0, 0, 2, 2}; // OOR in 2nd settle
        vecs[6] = '{0, 3, 5, 0, -1,  1, 2, 0, 0, 0, 0, 2, 2}; // illegal op
        vecs[7] = '{0, 1, 0, 0, -1,  2, 0, 0, 0, 0, 0, 2, 3}; // zero-step inc
        vecs[8] = '{0, 0, 7, 0, -1,  6, 0, 0, 0, 1, 1, 2, 3}; // load lane 0

        SYNC_RST  = 1'b1;
        REQ_VALID = 1'b0;
        REQ_LANE  = '0;
        REQ_OP    = '0;
        REQ_STEPS = '0;
        DELAY_LINE_OUT_OF_RANGE = '0;
        oor_exp   = 0;

        repeat (3) @(posedge FAB_CLK);
        @(negedge FAB_CLK);
        SYNC_RST = 1'b0;
        chk("rst_ready", int'(REQ_READY), 1);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done_valid", int'(DONE_VALID), 0);
        chk("rst_done_status", int'(DONE_STATUS), 0);
        chk("rst_done_taps", int'(DONE_TAPS), 0);
        chk("rst_load", int'(DELAY_LINE_LOAD), 0);
        chk("rst_move", int'(DELAY_LINE_MOVE), 0);
        chk("rst_dir", int'(DELAY_LINE_DIRECTION), 0);
        chk("rst_tap_count", int'(TAP_COUNT), 16'h0101);
`ifdef IOD_DLY_OOR_CNT_EN
        chk("rst_oor_count", int'(OOR_COUNT), 0);
`endif

        for (int vi = 0; vi < NV; vi++) begin
            v = vecs[vi];
            wait_idle();
            REQ_VALID = 1'b1;
            REQ_LANE  = v.lane[0:0];
            REQ_OP    = v.op[1:0];
            REQ_STEPS = v.steps[7:0];
            @(posedge FAB_CLK);   // accept edge, cycle 0
            n_moves = 0; first_mv = -1; last_mv = -1; load_seen = 0; done_cyc = -1;
            for (int k = 1; k <= 300 && done_cyc < 0; k++) begin
                @(negedge FAB_CLK);
                if (k == 1) begin
                    // Scramble request fields: the DUT must have captured them.
                    REQ_VALID = 1'b0;
                    REQ_LANE  = ~REQ_LANE;
                    REQ_OP    = 2'b11;
                    REQ_STEPS = 8'hA5;
                    chk("busy_c1", int'(BUSY), 1);
                    chk("ready_c1", int'(REQ_READY), 0);
                end
                DELAY_LINE_OUT_OF_RANGE = (k >= v.oor_lo && k <= v.oor_hi) ? (2'b01 << v.lane) : 2'b00;
                if (DELAY_LINE_MOVE != 2'b00) begin
                    n_moves++;
                    if (first_mv < 0) first_mv = k;
                    last_mv = k;
                    chk("move_lane", int'(DELAY_LINE_MOVE), 1 << v.lane);
                    chk("move_dir", int'(DELAY_LINE_DIRECTION), v.dir);
                end
                if (DELAY_LINE_LOAD != 2'b00) begin
                    load_seen = k;
                    chk("load_lane", int'(DELAY_LINE_LOAD), 1 << v.lane);
                end
                if (DONE_VALID === 1'b1) begin
                    done_cyc = k;
                    chk("done_status", int'(DONE_STATUS), v.status);
                    chk("done_taps", int'(DONE_TAPS), v.taps);
                end
            end
            DELAY_LINE_OUT_OF_RANGE = '0;
            chk("done_cycle", done_cyc, v.done_cyc);
            chk("move_count", n_moves, v.moves);
            if (v.moves > 0) begin
                chk("first_move_cyc", first_mv, 2);
                chk("last_move_cyc", last_mv, 2 + (v.moves - 1) * 5);
            end
            chk("load_cycle", load_seen, v.load_cyc);
            if (v.status == 1) oor_exp++;
            @(negedge FAB_CLK);
            chk("ready_after_done", int'(REQ_READY), 1);
            chk("done_valid_drop", int'(DONE_VALID), 0);
            chk("tap_count", int'(TAP_COUNT), (v.tap1 << 8) | v.tap0);
            chk("direction", int'(DELAY_LINE_DIRECTION), v.dir);
`ifdef IOD_DLY_OOR_CNT_EN
            chk("oor_count", int'(OOR_COUNT), oor_exp);
`endif
            $display("[TB] vec %0d lane=%0d op=%0d steps=%0d done@%0d status=%0d taps=%0d moves=%0d tap_count=%h",
                     vi, v.lane, v.op, v.steps, done_cyc, DONE_STATUS, DONE_TAPS, n_moves, TAP_COUNT);
        end

        // Reset in the middle of a 3-step increment on lane 1.
        wait_idle();
        REQ_VALID = 1'b1;
        REQ_LANE  = 1'b1;
        REQ_OP    = 2'b01;
        REQ_STEPS = 8'd3;
        @(posedge FAB_CLK);
        rst_done_seen = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge FAB_CLK);
            if (k == 1) REQ_VALID = 1'b0;
            if (k == 8) SYNC_RST = 1'b1;
            if (k == 9) begin
                SYNC_RST = 1'b0;
                chk("midrst_ready", int'(REQ_READY), 1);
                chk("midrst_busy", int'(BUSY), 0);
                chk("midrst_taps", int'(TAP_COUNT), 16'h0101);
                chk("midrst_dir", int'(DELAY_LINE_DIRECTION), 0);
                chk("midrst_move", int'(DELAY_LINE_MOVE), 0);
`ifdef IOD_DLY_OOR_CNT_EN
                chk("midrst_oor_count", int'(OOR_COUNT), 0);
`endif
            end
            if (DONE_VALID === 1'b1) rst_done_seen = 1'b1;
        end
        chk("midrst_no_done", int'(rst_done_seen), 0);
        chk("midrst_taps_end", int'(TAP_COUNT), 16'h0101);
        $display("[TB] mid-op reset: done_seen=%0d tap_count=%h ready=%0d", rst_done_seen, TAP_COUNT, REQ_READY);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
